rx_symbol_packer: RTL

//  Parametrised PIPE RX gasket: packs a decoded symbol stream into 1/2/4-symbol PCLK words.

---
 rtl/rx_gasket_pkg.sv | 28 ++
 rtl/rx_symbol_packer_if.sv | 13 +
 rtl/rx_word_fifo.sv | 56 +++++
 rtl/rx_symbol_packer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rx_gasket_pkg.sv
// Shared types and constants for the PIPE RX symbol packer: width_sel encodings,
// default comma/skip symbols, alignment state and the symbols-per-word decode.
package rx_gasket_pkg;

    localparam logic [1:0] WIDTH_SEL_1SYM = 2'd0;
    localparam logic [1:0] WIDTH_SEL_2SYM = 2'd1;
    localparam logic [1:0] WIDTH_SEL_MAX  = 2'd2;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;  // K28.5
    localparam logic [7:0] SKP_SYM_DEFAULT = 8'h1C;  // K28.0

    typedef enum logic {
        UNALIGNED = 1'b0,
        ALIGNED   = 1'b1
    } align_state_e;

    function automatic int syms_per_word(input logic [1:0] width_sel, input int max_syms);
        int n;
        case (width_sel)
            WIDTH_SEL_1SYM: n = 1;
            WIDTH_SEL_2SYM: n = 2;
            WIDTH_SEL_MAX:  n = max_syms;
            default:        n = max_syms;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rx_symbol_packer_if.sv
// Ready/valid word stream from the symbol packer towards the MAC-side RX logic.
interface rx_symbol_packer_if #(
    parameter int SYM_W    = 8,
    parameter int MAX_SYMS = 4
);
    logic                      out_valid;
    logic                      out_ready;
    logic [MAX_SYMS*SYM_W-1:0] out_data;
    logic [MAX_SYMS-1:0]       out_datak;

    modport master (output out_valid, output out_data, output out_datak, input out_ready);
    modport slave  (input out_valid, input out_data, input out_datak, output out_ready);
endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO; a push while full is accepted only when a pop frees a slot
// in the same cycle.
module rx_word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             PCLK,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge PCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rx_symbol_packer.sv
// PIPE RX gasket: COM alignment, SKP removal and packing of decoded symbols into
// 1/2/MAX_SYMS-symbol words with a per-slot K mask, buffered by a word FIFO.
module rx_symbol_packer
    import rx_gasket_pkg::*;
#(
    parameter int               SYM_W      = 8,
    parameter int               MAX_SYMS   = 4,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [SYM_W-1:0] COM_SYM    = SYM_W'(COM_SYM_DEFAULT),
    parameter logic [SYM_W-1:0] SKP_SYM    = SYM_W'(SKP_SYM_DEFAULT)
) (
    input  logic                      PCLK,
    input  logic                      Rst,
    input  logic [1:0]                width_sel,
    input  logic                      rx_elec_idle,
    input  logic                      sym_valid,
    input  logic [SYM_W-1:0]          sym_data,
    input  logic                      sym_datak,
    rx_symbol_packer_if.master        out_if,
    output logic                      aligned,
    output logic                      align_err,
    output logic                      overflow
);
    localparam int SLOT_W = $clog2(MAX_SYMS + 1);
    localparam int IDX_W  = $clog2(MAX_SYMS);
    localparam int WORD_W = MAX_SYMS * (SYM_W + 1);

    align_state_e                  state_q, state_d;
    logic [SLOT_W-1:0]             slot_q, slot_d;
    logic [1:0]                    width_q, width_d;
    logic [MAX_SYMS-1:0][SYM_W-1:0] data_q, data_d;
    logic [MAX_SYMS-1:0]           datak_q, datak_d;
    logic                          align_err_q, align_err_d;
    logic                          overflow_q, overflow_d;

    logic              is_com, is_skp, accept, restart;
    logic [1:0]        eff_width;
    logic [SLOT_W-1:0] words_n, wr_slot;
    logic              push;
    logic [WORD_W-1:0] push_word, head_word;
    logic              fifo_empty, fifo_full, fifo_pop;

    assign fifo_pop = !fifo_empty && out_if.out_ready;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        width_d     = width_q;
        data_d      = data_q;
        datak_d     = datak_q;
        align_err_d = 1'b0;
        push        = 1'b0;
        push_word   = '0;
        wr_slot     = '0;

        is_com  = sym_valid && sym_datak && (sym_data == COM_SYM);
        is_skp  = sym_valid && sym_datak && (sym_data == SKP_SYM);
        restart = (state_q == ALIGNED) && is_com && (slot_q != '0);
        accept  = (state_q == UNALIGNED) ? is_com : (sym_valid && !is_skp);

        // Width is only sampled at a word boundary; a restarted word keeps the held width.
        eff_width = (slot_q == '0) ? width_sel : width_q;
        words_n   = SLOT_W'(syms_per_word(eff_width, MAX_SYMS));
        if (slot_q == '0) width_d = width_sel;

        if (rx_elec_idle) begin
            state_d = UNALIGNED;
            slot_d  = '0;
        end else if (accept) begin
            state_d     = ALIGNED;
            align_err_d = restart;
            wr_slot     = (state_q == UNALIGNED || restart) ? '0 : slot_q;
            if (wr_slot == '0) begin
                data_d  = '0;
                datak_d = '0;
            end
            data_d[wr_slot[IDX_W-1:0]]  = sym_data;
            datak_d[wr_slot[IDX_W-1:0]] = sym_datak;
            slot_d = wr_slot + SLOT_W'(1);
            if (slot_d == words_n) begin
                push      = 1'b1;
                push_word = {datak_d, data_d};
                slot_d    = '0;
            end
        end

        overflow_d = overflow_q || (push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            state_q     <= UNALIGNED;
            slot_q      <= '0;
            width_q     <= width_sel;
            data_q      <= '0;
            datak_q     <= '0;
            align_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            width_q     <= width_d;
            data_q      <= data_d;
            datak_q     <= datak_d;
            align_err_q <= align_err_d;
            overflow_q  <= overflow_d;
        end
    end

    rx_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .PCLK      (PCLK),
        .Rst       (Rst),
        .push      (push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head_data (head_word),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_if.out_valid = !fifo_empty;
    assign {out_if.out_datak, out_if.out_data} = fifo_empty ? '0 : head_word;

    assign aligned   = (state_q == ALIGNED);
    assign align_err = align_err_q;
    assign overflow  = overflow_q;

endmodule
